// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader.
// Holds the FSM state encoding and the default fill byte that is returned
// for unloaded addresses and outside RUN.
package instr_mem_loader_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_RUN  = ST_RUN
    } state_t;

    localparam logic [7:0] FILL_INSTR_DEFAULT = 8'h00;

endpackage

// File: rtl/instr_mem_loader_ram.sv
// Byte-wide DEPTH x 8 storage: synchronous write, asynchronous read.
// Contents are deliberately not reset; the owner masks stale data.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write byte
//   raddr  - read address
//   rdata  - read byte (combinational)
module instr_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction-side responder for the 8-bit processor with a program-load path.
// A valid/ready byte stream writes the program from address 0; the processor
// is held in reset until a non-empty program is loaded and loading is closed.
//
//   state | meaning
//   IDLE  | no program; CPU held in reset, waiting for LOAD_EN
//   LOAD  | accepting program bytes, CPU held in reset
//   RUN   | program closed; CPU released, INSTR serves mem[PC]
//
// Ports:
//   CLK, RST   - clock, async active-high reset
//   LOAD_EN    - level request for load mode; falling edge closes the load
//   WR_VALID / WR_DATA / WR_READY - program byte handshake
//   PC / INSTR - instruction fetch (combinational)
//   CPU_RST    - processor reset, high outside RUN
//   LOAD_CNT   - number of bytes loaded (0..DEPTH)
//   FULL       - LOAD_CNT == DEPTH
//   RUNNING    - state is RUN
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int         DEPTH      = 256,
    parameter int         AW         = 8,
    parameter logic [7:0] FILL_INSTR = FILL_INSTR_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          LOAD_EN,
    input  logic          WR_VALID,
    input  logic [7:0]    WR_DATA,
    output logic          WR_READY,
    input  logic [AW-1:0] PC,
    output logic [7:0]    INSTR,
    output logic          CPU_RST,
    output logic [AW:0]   LOAD_CNT,
    output logic          FULL,
    output logic          RUNNING
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    state_t      state_q, state_d;
    logic [AW:0] cnt_d;
    logic        xfer;
    logic [7:0]  ram_rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = LOAD_CNT;
        xfer    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (LOAD_EN) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                xfer = WR_VALID & WR_READY;
                if (xfer) begin
                    cnt_d = LOAD_CNT + (AW+1)'(1);
                end
                // A byte accepted on the closing edge still counts as program.
                if (!LOAD_EN) begin
                    state_d = (cnt_d == '0) ? S_IDLE : S_RUN;
                end
            end
            S_RUN: begin
                if (LOAD_EN) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so that WR_READY is
    // already valid in the first LOAD cycle and CPU_RST toggles on the RUN edges.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            LOAD_CNT <= '0;
            WR_READY <= 1'b0;
            CPU_RST  <= 1'b1;
            RUNNING  <= 1'b0;
            FULL     <= 1'b0;
        end else begin
            state_q  <= state_d;
            LOAD_CNT <= cnt_d;
            WR_READY <= (state_d == S_LOAD) && (cnt_d != DEPTH_CNT);
            CPU_RST  <= (state_d != S_RUN);
            RUNNING  <= (state_d == S_RUN);
            FULL     <= (cnt_d == DEPTH_CNT);
        end
    end

    instr_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (CLK),
        .we    (xfer),
        .waddr (LOAD_CNT[AW-1:0]),
        .wdata (WR_DATA),
        .raddr (PC),
        .rdata (ram_rdata)
    );

    // Bytes beyond the loaded length are stale from an earlier program.
    assign INSTR = ((state_q == S_RUN) && ({1'b0, PC} < LOAD_CNT)) ? ram_rdata : FILL_INSTR;

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_en;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [7:0] pc;
    logic [7:0] instr;
    logic       cpu_rst;
    logic [8:0] load_cnt;
    logic       full;
    logic       running;

    instr_mem_loader #(.DEPTH(256), .AW(8), .FILL_INSTR(8'h00)) dut (
        .CLK      (clk),
        .RST      (rst),
        .LOAD_EN  (load_en),
        .WR_VALID (wr_valid),
        .WR_DATA  (wr_data),
        .WR_READY (wr_ready),
        .PC       (pc),
        .INSTR    (instr),
        .CPU_RST  (cpu_rst),
        .LOAD_CNT (load_cnt),
        .FULL     (full),
        .RUNNING  (running)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // bench model: 0 idle, 1 load, 2 run
    int          m_state;
    int          m_cnt;
    bit          m_ready;
    logic [7:0]  m_mem [256];
    logic [15:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_ready = 1'b0;
        exp_q.delete();
    endtask

    // One clock cycle: drive, check the pre-edge ready, advance model, check outputs.
    task automatic step(input bit len, input bit v, input logic [7:0] d);
        bit xfer;
        load_en  = len;
        wr_valid = v;
        wr_data  = d;
        pc       = 8'd0;
        #1;
        check("wr_ready", wr_ready, m_ready);
        xfer = (m_state == 1) && v && m_ready;
        @(posedge clk); #1;
        case (m_state)
            0: if (len) begin m_state = 1; m_cnt = 0; exp_q.delete(); end
            1: begin
                if (xfer) begin
                    m_mem[m_cnt] = d;
                    exp_q.push_back({8'(m_cnt), d});
                    m_cnt++;
                end
                if (!len) m_state = (m_cnt == 0) ? 0 : 2;
            end
            default: if (len) begin m_state = 1; m_cnt = 0; exp_q.delete(); end
        endcase
        m_ready = (m_state == 1) && (m_cnt != 256);
        check("cpu_rst",  cpu_rst,  m_state != 2);
        check("running",  running,  m_state == 2);
        check("load_cnt", load_cnt, m_cnt);
        check("full",     full,     m_cnt == 256);
        check("instr_pc0", instr, (m_state == 2 && m_cnt > 0) ? m_mem[0] : 8'h00);
    endtask

    // Drain the scoreboard: every accepted byte must be readable at its address.
    task automatic verify_run();
        logic [15:0] e;
        wr_valid = 1'b0;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            pc = e[15:8];
            #1;
            check("instr_run", instr, e[7:0]);
        end
        if (m_cnt < 256) begin
            pc = 8'(m_cnt);
            #1;
            check("instr_fill", instr, 8'h00);
        end
        pc = 8'd0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; pc = 8'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset mid-load after 3 bytes
        step(1, 0, 8'h00);
        step(1, 1, 8'h11);
        step(1, 1, 8'h22);
        step(1, 1, 8'h33);
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_cpu_rst",  cpu_rst,  1'b1);
        check("rst_running",  running,  1'b0);
        check("rst_load_cnt", load_cnt, 9'd0);
        check("rst_wr_ready", wr_ready, 1'b0);
        check("rst_full",     full,     1'b0);
        check("rst_instr",    instr,    8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();

        // basic load
        step(1, 0, 8'h00);
        step(1, 1, 8'h41);
        step(1, 1, 8'h82);
        step(1, 1, 8'hC3);
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        verify_run();

        // backpressure gaps; last byte coincides with LOAD_EN falling
        step(1, 0, 8'h00);
        step(1, 1, 8'hA0);
        step(1, 0, 8'hEE);
        step(1, 1, 8'hA1);
        step(1, 0, 8'hEE);
        step(1, 1, 8'hA2);
        step(1, 0, 8'hEE);
        step(0, 1, 8'hA3);
        check("bp_count", load_cnt, 9'd4);
        verify_run();

        // full: 260 bytes, last 4 dropped
        step(1, 0, 8'h00);
        for (int i = 0; i < 260; i++) step(1, 1, 8'(i));
        check("full_flag", full, 1'b1);
        step(0, 1, 8'hFF);
        verify_run();

        // empty close
        step(1, 0, 8'h00);
        step(1, 0, 8'h00);
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        check("empty_running", running, 1'b0);

        // reload from RUN
        step(1, 0, 8'h00);
        step(1, 1, 8'h41);
        step(1, 1, 8'h82);
        step(1, 1, 8'hC3);
        step(0, 0, 8'h00);
        verify_run();
        step(1, 0, 8'h00);
        check("reload_cpu_rst", cpu_rst, 1'b1);
        step(1, 1, 8'h10);
        step(1, 1, 8'h20);
        step(0, 0, 8'h00);
        pc = 8'd2;
        #1;
        check("reload_masked", instr, 8'h00);
        pc = 8'd0;
        @(posedge clk); #1;
        verify_run();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
